// File: rtl/ctr_crypt_pkg.sv
`default_nettype none
// ============================================================================
// ctr_crypt_pkg : shared widths, pad request record and FSM states
// Rev 1.0
// ============================================================================
package ctr_crypt_pkg;

   localparam int LINE_BITS  = 512;
   localparam int ADDR_BITS  = 26;
   localparam int NONCE_BITS = 56;

   typedef struct packed {
      logic [ADDR_BITS-1:0]  addr;
      logic [NONCE_BITS-1:0] nonce;
   } pad_req_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_PAD = 2'd1,
      OUT      = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ctr_line_crypt.sv
`default_nettype none
// ============================================================================
// ctr_line_crypt : counter-mode line XOR stage; one line in flight to AES pad.
// Optional pad watchdog: CTR_LINE_CRYPT_WATCHDOG_EN.  Rev 1.0
// ============================================================================
module ctr_line_crypt
   import ctr_crypt_pkg::*;
#(
   parameter int PAD_TIMEOUT = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_BITS-1:0]  in_addr,
   input  logic [NONCE_BITS-1:0] in_nonce,
   input  logic [LINE_BITS-1:0]  in_data,
   output logic                  pad_req_valid,
   output logic [ADDR_BITS-1:0]  pad_req_addr,
   output logic [NONCE_BITS-1:0] pad_req_nonce,
   input  logic                  pad_valid,
   input  logic [LINE_BITS-1:0]  pad,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_BITS-1:0]  out_addr,
   output logic [LINE_BITS-1:0]  out_data,
   output logic                  err_timeout
);

   state_t               state;
   state_t               state_nx;
   pad_req_t             req;
   logic                 req_pulse;
   logic [LINE_BITS-1:0] data_q;
   logic [LINE_BITS-1:0] out_data_q;
   logic                 accept;
   logic                 capture;
   logic                 timeout;

   assign accept  = (state == IDLE) && in_valid;
   assign capture = (state == WAIT_PAD) && pad_valid;

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = WAIT_PAD;
         end
         WAIT_PAD: begin
            if (pad_valid)    state_nx = OUT;
            else if (timeout) state_nx = IDLE;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         req_pulse  <= 1'b0;
         req        <= '0;
         out_data_q <= '0;
      end else begin
         state     <= state_nx;
         req_pulse <= accept;
         if (accept)  req        <= '{addr: in_addr, nonce: in_nonce};
         if (capture) out_data_q <= data_q ^ pad;
      end
   end

   // The held line is pure payload; reset only needs to drop control state.
   always_ff @(posedge clock) begin
      if (accept) data_q <= in_data;
   end

`ifdef CTR_LINE_CRYPT_WATCHDOG_EN
   localparam int WD_BITS = ($clog2(PAD_TIMEOUT + 1) > 8) ? $clog2(PAD_TIMEOUT + 1) : 8;

   logic [WD_BITS-1:0] wd_cnt;
   logic               err_q;

   // Fires on the cycle that would bring the count to PAD_TIMEOUT.
   assign timeout = (state == WAIT_PAD) && !pad_valid
                    && (wd_cnt == WD_BITS'(PAD_TIMEOUT - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (accept)
            wd_cnt <= '0;
         else if ((state == WAIT_PAD) && !pad_valid)
            wd_cnt <= wd_cnt + 1'b1;
         if (timeout) err_q <= 1'b1;
      end
   end

   assign err_timeout = err_q;
`else
   assign timeout     = 1'b0;
   assign err_timeout = 1'b0;
`endif

   assign pad_req_valid = req_pulse;
   assign pad_req_addr  = req.addr;
   assign pad_req_nonce = req.nonce;
   assign out_addr      = req.addr;
   assign out_data      = out_data_q;

endmodule
`default_nettype wire
